// File: rtl/ped_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller: phase encoding,
// default phase durations and the lamp bundle used by the output decode.
package ped_ctrl_pkg;

  // Phase encoding, shared with the display and LED-matrix blocks.
  localparam logic [1:0] PH_STOP  = 2'd0;
  localparam logic [1:0] PH_CLEAR = 2'd1;
  localparam logic [1:0] PH_WALK  = 2'd2;

  // Default durations and thresholds, in 1 Hz ticks.
  localparam int unsigned STOP_T_DEF  = 10;
  localparam int unsigned CLEAR_T_DEF = 2;
  localparam int unsigned WALK_T_DEF  = 15;
  localparam int unsigned YEL_T_DEF   = 2;
  localparam int unsigned QUICK_T_DEF = 5;

  // Pedestrian lamp bundle; exactly one field is high at any time.
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  // Fixed STOP -> CLEAR -> WALK -> STOP ordering. The unused code 3 falls
  // back to STOP so a corrupted state recovers on its next advance.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_STOP:  nxt = PH_CLEAR;
      PH_CLEAR: nxt = PH_WALK;
      default:  nxt = PH_STOP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ped_phase_ctrl_timer.sv
// Phase countdown: 4-bit counter that loads a phase duration and decrements
// on enabled ticks, stopping at 1. expire flags an enabled tick seen at 1.
module phase_timer #(
  parameter logic [3:0] RST_VAL = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       expire
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load wins over decrement; the count never drops below 1 so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q > 4'd1)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign expire = (cnt_q == 4'd1) & en;

endmodule

// File: rtl/ped_phase_ctrl.sv
// Pedestrian phase sequencer: STOP -> CLEAR -> WALK cycle, request latch and
// combinational decode of the countdown, lamps and LED-matrix selects.
module ped_phase_ctrl
  import ped_ctrl_pkg::*;
#(
  parameter int unsigned STOP_T  = STOP_T_DEF,
  parameter int unsigned CLEAR_T = CLEAR_T_DEF,
  parameter int unsigned WALK_T  = WALK_T_DEF,
  parameter int unsigned YEL_T   = YEL_T_DEF,
  parameter int unsigned QUICK_T = QUICK_T_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause,
  input  logic       change_state,
  input  logic       ped_req,
  output logic [3:0] second,
  output logic [1:0] phase,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       quick,
  output logic       pattern,
  output logic       req_pending
);

  localparam logic [3:0] STOP_V  = 4'(STOP_T);
  localparam logic [3:0] CLEAR_V = 4'(CLEAR_T);
  localparam logic [3:0] WALK_V  = 4'(WALK_T);
  localparam logic [3:0] YEL_V   = 4'(YEL_T);
  localparam logic [3:0] QUICK_V = 4'(QUICK_T);

  logic [1:0] state_q, state_d;
  logic       req_q, req_d;
  logic       qtick;
  logic       force_adv;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       expire;
  logic       in_walk;
  lamp_t      lamps;

  function automatic logic [3:0] phase_dur(input logic [1:0] ph);
    logic [3:0] d;
    case (ph)
      PH_CLEAR: d = CLEAR_V;
      PH_WALK:  d = WALK_V;
      default:  d = STOP_V;
    endcase
    return d;
  endfunction

  // pause freezes both the countdown and forced advances.
  assign qtick     = tick & ~pause;
  assign force_adv = change_state & ~pause;

  phase_timer #(
    .RST_VAL (STOP_V)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (qtick),
    .cnt      (cnt),
    .expire   (expire)
  );

  // Next phase: forced advance beats expiry; STOP only leaves on a request
  // that was already latched before the expiring tick.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (force_adv) begin
      state_d = next_phase(state_q);
      load    = 1'b1;
    end else if (expire) begin
      if ((state_q != PH_STOP) || req_q) begin
        state_d = next_phase(state_q);
        load    = 1'b1;
      end
    end
    load_val = phase_dur(state_d);
  end

  // Request latch: cleared on WALK entry, set by the button outside WALK.
  always_comb begin
    req_d = req_q;
    if ((state_d == PH_WALK) && (state_q != PH_WALK)) begin
      req_d = 1'b0;
    end else if (ped_req && (state_q != PH_WALK)) begin
      req_d = 1'b1;
    end
  end

  // Phase and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PH_STOP;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Output decode, purely from the registered phase and count.
  always_comb begin
    in_walk      = (state_q == PH_WALK);
    lamps.red    = ~in_walk;
    lamps.green  = in_walk & (cnt > YEL_V);
    lamps.yellow = in_walk & (cnt <= YEL_V);
  end

  assign red         = lamps.red;
  assign yellow      = lamps.yellow;
  assign green       = lamps.green;
  assign quick       = in_walk & (cnt <= QUICK_V);
  assign pattern     = in_walk;
  assign second      = in_walk ? cnt : 4'd0;
  assign phase       = state_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_ped_phase_ctrl.sv
// Scoreboard bench for ped_phase_ctrl: the stimulus thread queues the
// hand-derived expected outputs for each cycle, the monitor thread pops and
// compares them on the falling edge after the corresponding rising edge.
module tb_ped_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       change_state = 1'b0;
  logic       ped_req = 1'b0;
  logic [3:0] second;
  logic [1:0] phase;
  logic       red, yellow, green, quick, pattern, req_pending;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] ph;
    logic [3:0] sec;
    logic [2:0] ryg;
    logic       q;
    logic       pat;
    logic       req;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ped_phase_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .pause        (pause),
    .change_state (change_state),
    .ped_req      (ped_req),
    .second       (second),
    .phase        (phase),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .quick        (quick),
    .pattern      (pattern),
    .req_pending  (req_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Queue the outputs expected after the next rising edge.
  task automatic expect_o(input string nm, input logic [1:0] ph, input logic [3:0] sec,
                          input logic [2:0] ryg, input logic q, input logic pat,
                          input logic req);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.name = nm;
    e.ph = ph;
    e.sec = sec;
    e.ryg = ryg;
    e.q = q;
    e.pat = pat;
    e.req = req;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then return them to idle just after the edge.
  task automatic step(input logic t, input logic p, input logic cs, input logic pr);
    tick = t;
    pause = p;
    change_state = cs;
    ped_req = pr;
    @(posedge clk);
    #1;
    tick = 1'b0;
    pause = 1'b0;
    change_state = 1'b0;
    ped_req = 1'b0;
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while ((exp_q.size() > 0) && (exp_q[0].cyc <= cyc_cnt)) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc_cnt) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc_cnt);
      end else if ({phase, second, red, yellow, green, quick, pattern, req_pending} !==
                   {mon_e.ph, mon_e.sec, mon_e.ryg, mon_e.q, mon_e.pat, mon_e.req}) begin
        n_fail++;
        $display("FAIL %s: got phase=%0d second=%0d ryg=%b quick=%b pattern=%b req=%b, expected phase=%0d second=%0d ryg=%b quick=%b pattern=%b req=%b",
                 mon_e.name, phase, second, {red, yellow, green}, quick, pattern, req_pending,
                 mon_e.ph, mon_e.sec, mon_e.ryg, mon_e.q, mon_e.pat, mon_e.req);
      end else begin
        $display("ok   %s: cycle %0d phase=%0d second=%0d ryg=%b quick=%b pattern=%b req=%b",
                 mon_e.name, cyc_cnt, phase, second, {red, yellow, green}, quick, pattern, req_pending);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held over two edges.
    #1;
    expect_o("reset0", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    expect_o("reset1", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    rst = 1'b1;

    // Idle: 30 ticks without a request stay in STOP.
    for (int i = 1; i <= 30; i++) begin
      expect_o("idle_stop", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
      step(1, 0, 0, 0);
    end
    // Request while holding at 1: latched without a tick, granted on next tick.
    expect_o("req_latch", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, 1);
    expect_o("hold_grant", 2'd1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    expect_o("hold_clear", 2'd1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    expect_o("hold_walk", 2'd2, 4'd15, 3'b001, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0, 0);

    // Request service: ped_req with the 3rd tick after reset.
    rst = 1'b0;
    expect_o("reset2", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 9)
        expect_o("svc_stop", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, (i >= 3) ? 1'b1 : 1'b0);
      else if (i <= 11)
        expect_o("svc_clear", 2'd1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
      else
        expect_o("svc_walk", 2'd2, 4'd15, 3'b001, 1'b0, 1'b1, 1'b0);
      step(1, 0, 0, (i == 3) ? 1'b1 : 1'b0);
    end

    // WALK countdown down to 8.
    for (int s = 14; s >= 8; s--) begin
      expect_o("walk_cd", 2'd2, 4'(s), 3'b001, 1'b0, 1'b1, 1'b0);
      step(1, 0, 0, 0);
    end
    // Pause at 8 for 20 ticks with a change_state pulse inside.
    for (int i = 1; i <= 20; i++) begin
      expect_o("pause_hold", 2'd2, 4'd8, 3'b001, 1'b0, 1'b1, 1'b0);
      step(1, 1, (i == 10) ? 1'b1 : 1'b0, 0);
    end
    // Resume from 8: quick at 5 and below, yellow at 2 and below.
    for (int s = 7; s >= 1; s--) begin
      expect_o("walk_resume", 2'd2, 4'(s), (s <= 2) ? 3'b010 : 3'b001,
               (s <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      step(1, 0, 0, 0);
    end
    expect_o("walk_exit", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0, 0);

    // Forced advance with tick and ped_req at STOP count 7.
    for (int i = 1; i <= 3; i++) begin
      expect_o("stop_to7", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
      step(1, 0, 0, 0);
    end
    expect_o("force_clear", 2'd1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    step(1, 0, 1, 1);
    expect_o("force_cnt2", 2'd1, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0);
    expect_o("force_walk", 2'd2, 4'd15, 3'b001, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0, 0);

    // ped_req during WALK is discarded; count down to 4.
    expect_o("walk_req_drop", 2'd2, 4'd14, 3'b001, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0, 1);
    for (int s = 13; s >= 4; s--) begin
      expect_o("walk_to4", 2'd2, 4'(s), 3'b001, (s <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      step(1, 0, 0, 0);
    end

    // Reset mid-WALK, with tick and change_state also asserted.
    rst = 1'b0;
    expect_o("reset_mid", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(1, 0, 1, 0);
    rst = 1'b1;
    expect_o("post_reset", 2'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0);

    // Drain the scoreboard.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
